// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-access stage: byte/half/word loads and stores over a valid/ready bus
//
// Purpose: takes the ALU result as effective address, issues one aligned bus
// transaction per load/store, formats load data for write-back and stalls the
// pipeline while the transaction is in flight.
//
// Ports:
//   CLK, RST            clock (rising edge), asynchronous active-high reset
//   MemRead, MemWrite   load / store request (store wins when both set)
//   Funct3              access size and signedness (B, H, W, BU, HU)
//   ALUResult           effective address
//   WriteData           store data (rs2)
//   ReadData            formatted load result, registered, held between loads
//   Stall               freeze PC and register file
//   Done                one-cycle completion pulse
//   Fault               misaligned / illegal funct3 (same cycle) or bus timeout (with Done)
//   BusAddr..BusValid   word-aligned bus request, held stable until BusReady
//   BusReady, BusRData  slave acceptance and same-cycle read data

module load_store_unit #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_WAIT   = 255
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [ADDR_WIDTH-1:0] ALUResult,
    input  logic [WIDTH-1:0]      WriteData,
    output logic [WIDTH-1:0]      ReadData,
    output logic                  Stall,
    output logic                  Done,
    output logic                  Fault,
    output logic [ADDR_WIDTH-1:0] BusAddr,
    output logic [WIDTH-1:0]      BusWData,
    output logic [3:0]            BusWStrb,
    output logic                  BusWrite,
    output logic                  BusValid,
    input  logic                  BusReady,
    input  logic [WIDTH-1:0]      BusRData
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    logic [1:0]            state_q,     state_d;
    logic [WIDTH-1:0]      read_data_q, read_data_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q,  bus_addr_d;
    logic [WIDTH-1:0]      bus_wdata_q, bus_wdata_d;
    logic [3:0]            bus_wstrb_q, bus_wstrb_d;
    logic                  bus_write_q, bus_write_d;
    logic                  bus_valid_q, bus_valid_d;
    logic [1:0]            off_q,       off_d;
    logic [2:0]            funct3_q,    funct3_d;
    logic [CW-1:0]         wait_q,      wait_d;
    logic                  timeout_q,   timeout_d;

    logic             req;
    logic             bad;
    logic [WIDTH-1:0] store_data;
    logic [3:0]       store_strb;
    logic [7:0]       load_byte;
    logic [15:0]      load_half;
    logic [WIDTH-1:0] load_data;

    assign req = MemRead | MemWrite;

    // Illegal encodings, stores with unsigned-load encodings, and misalignment.
    always_comb begin
        bad = 1'b0;
        case (Funct3)
            3'b011, 3'b110, 3'b111: bad = 1'b1;
            3'b100:                 bad = MemWrite;
            3'b101:                 bad = MemWrite | ALUResult[0];
            3'b001:                 bad = ALUResult[0];
            3'b010:                 bad = (ALUResult[1:0] != 2'b00);
            default:                bad = 1'b0;
        endcase
    end

    // Store data is replicated across lanes so the strobes alone pick the target bytes.
    always_comb begin
        store_data = WriteData;
        store_strb = 4'b1111;
        case (Funct3)
            3'b000: begin
                store_data = {4{WriteData[7:0]}};
                store_strb = 4'b0001 << ALUResult[1:0];
            end
            3'b001: begin
                store_data = {2{WriteData[15:0]}};
                store_strb = ALUResult[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                store_data = WriteData;
                store_strb = 4'b1111;
            end
        endcase
        if (!MemWrite) begin
            store_strb = 4'b0000;
        end
    end

    // Lane selection and extension for the load result.
    assign load_byte = BusRData[{off_q, 3'b000} +: 8];
    assign load_half = off_q[1] ? BusRData[31:16] : BusRData[15:0];

    always_comb begin
        case (funct3_q)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b100:  load_data = {24'd0, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b101:  load_data = {16'd0, load_half};
            default: load_data = BusRData;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        read_data_d = read_data_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wstrb_d = bus_wstrb_q;
        bus_write_d = bus_write_q;
        bus_valid_d = bus_valid_q;
        off_d       = off_q;
        funct3_d    = funct3_q;
        wait_d      = wait_q;
        timeout_d   = timeout_q;
        Stall       = 1'b0;
        Done        = 1'b0;
        Fault       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req && bad) begin
                    Fault = 1'b1;
                end else if (req) begin
                    Stall       = 1'b1;
                    bus_addr_d  = {ALUResult[ADDR_WIDTH-1:2], 2'b00};
                    bus_write_d = MemWrite;
                    bus_valid_d = 1'b1;
                    bus_wdata_d = store_data;
                    bus_wstrb_d = store_strb;
                    off_d       = ALUResult[1:0];
                    funct3_d    = Funct3;
                    wait_d      = '0;
                    timeout_d   = 1'b0;
                    state_d     = S_ACCESS;
                end
            end

            S_ACCESS: begin
                Stall = 1'b1;
                if (BusReady) begin
                    bus_valid_d = 1'b0;
                    if (!bus_write_q) begin
                        read_data_d = load_data;
                    end
                    state_d = S_DONE;
                end else if (wait_q == CW'(MAX_WAIT - 1)) begin
                    // Last allowed cycle passed without the slave answering.
                    bus_valid_d = 1'b0;
                    read_data_d = '0;
                    timeout_d   = 1'b1;
                    wait_d      = wait_q + CW'(1);
                    state_d     = S_DONE;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end

            S_DONE: begin
                // Requests seen here belong to the instruction just completed; ignore them.
                Done      = 1'b1;
                Fault     = timeout_q;
                wait_d    = '0;
                timeout_d = 1'b0;
                state_d   = S_IDLE;
            end

            default: begin
                state_d     = S_IDLE;
                bus_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            read_data_q <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wstrb_q <= '0;
            bus_write_q <= 1'b0;
            bus_valid_q <= 1'b0;
            off_q       <= '0;
            funct3_q    <= '0;
            wait_q      <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            read_data_q <= read_data_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wstrb_q <= bus_wstrb_d;
            bus_write_q <= bus_write_d;
            bus_valid_q <= bus_valid_d;
            off_q       <= off_d;
            funct3_q    <= funct3_d;
            wait_q      <= wait_d;
            timeout_q   <= timeout_d;
        end
    end

    assign ReadData = read_data_q;
    assign BusAddr  = bus_addr_q;
    assign BusWData = bus_wdata_q;
    assign BusWStrb = bus_wstrb_q;
    assign BusWrite = bus_write_q;
    assign BusValid = bus_valid_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit

module tb_load_store_unit;

    localparam int MAXW = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] ALUResult, WriteData;
    logic [31:0] ReadData;
    logic        Stall, Done, Fault;
    logic [31:0] BusAddr, BusWData;
    logic [3:0]  BusWStrb;
    logic        BusWrite, BusValid, BusReady;
    logic [31:0] BusRData;

    load_store_unit #(.WIDTH(32), .ADDR_WIDTH(32), .MAX_WAIT(MAXW)) dut (
        .CLK(CLK), .RST(RST), .MemRead(MemRead), .MemWrite(MemWrite),
        .Funct3(Funct3), .ALUResult(ALUResult), .WriteData(WriteData),
        .ReadData(ReadData), .Stall(Stall), .Done(Done), .Fault(Fault),
        .BusAddr(BusAddr), .BusWData(BusWData), .BusWStrb(BusWStrb),
        .BusWrite(BusWrite), .BusValid(BusValid), .BusReady(BusReady),
        .BusRData(BusRData)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        wr;
    } bus_t;

    typedef struct {
        logic        done;
        logic        fault;
        logic [31:0] rdata;
        int          stall;
    } rsp_t;

    bus_t bus_q[$];
    rsp_t rsp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Monitor: samples on the falling edge, away from the active edge.
    bus_t mb;
    rsp_t mr;
    int   stall_cnt  = 0;
    logic prev_valid = 1'b0;

    always @(negedge CLK) begin
        if (RST) begin
            stall_cnt  = 0;
            prev_valid = 1'b0;
        end else begin
            if (Stall) stall_cnt++;
            if (BusValid && !prev_valid) begin
                checks++;
                if (bus_q.size() == 0) begin
                    errors++;
                    $display("FAIL bus_unexpected: BusValid rose with addr=%h, required no request", BusAddr);
                end else begin
                    mb = bus_q.pop_front();
                    if (BusAddr !== mb.addr || BusWData !== mb.wdata ||
                        BusWStrb !== mb.strb || BusWrite !== mb.wr) begin
                        errors++;
                        $display("FAIL bus_req: got addr=%h wdata=%h strb=%b wr=%b, required addr=%h wdata=%h strb=%b wr=%b",
                                 BusAddr, BusWData, BusWStrb, BusWrite, mb.addr, mb.wdata, mb.strb, mb.wr);
                    end
                end
            end
            prev_valid = BusValid;
            if (Done || Fault) begin
                checks++;
                if (rsp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: Done=%b Fault=%b, required none", Done, Fault);
                end else begin
                    mr = rsp_q.pop_front();
                    if (Done !== mr.done || Fault !== mr.fault || ReadData !== mr.rdata ||
                        stall_cnt != mr.stall || Stall !== 1'b0) begin
                        errors++;
                        $display("FAIL rsp: got done=%b fault=%b rdata=%h stall_cycles=%0d stall=%b, required done=%b fault=%b rdata=%h stall_cycles=%0d stall=0",
                                 Done, Fault, ReadData, stall_cnt, Stall, mr.done, mr.fault, mr.rdata, mr.stall);
                    end
                end
                stall_cnt = 0;
            end
        end
    end

    // Good request: ready_at = ACCESS cycle with BusReady high, 0 = never.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdat, input int ready_at,
                          input bus_t eb, input rsp_t er);
        int n;
        bus_q.push_back(eb);
        rsp_q.push_back(er);
        MemRead = rd; MemWrite = wr; Funct3 = f3; ALUResult = addr; WriteData = wd;
        @(posedge CLK); #1;
        MemRead = 1'b0; MemWrite = 1'b0;
        n = (ready_at == 0) ? MAXW : ready_at;
        for (int k = 1; k <= n; k++) begin
            BusRData = rdat;
            BusReady = (k == ready_at);
            @(posedge CLK); #1;
        end
        BusReady = 1'b0;
        @(posedge CLK); #1;
    endtask

    // Rejected request: expect a same-cycle Fault and no bus activity.
    task automatic bad_req(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] rprev);
        rsp_t er;
        er = '{1'b0, 1'b1, rprev, 0};
        rsp_q.push_back(er);
        MemRead = rd; MemWrite = wr; Funct3 = f3; ALUResult = addr; WriteData = 32'h0;
        @(posedge CLK); #1;
        MemRead = 1'b0; MemWrite = 1'b0;
        @(posedge CLK); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b0;
        ALUResult = 32'h0; WriteData = 32'h0; BusReady = 1'b0; BusRData = 32'h0;
        #12;
        checks++;
        if (ReadData !== 32'h0 || Stall !== 1'b0 || Done !== 1'b0 || Fault !== 1'b0 ||
            BusValid !== 1'b0 || BusAddr !== 32'h0 || BusWStrb !== 4'h0 || BusWrite !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rdata=%h stall=%b done=%b fault=%b valid=%b addr=%h strb=%b wr=%b, required all 0",
                     ReadData, Stall, Done, Fault, BusValid, BusAddr, BusWStrb, BusWrite);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;

        // Loads: word with wait states, byte/half lanes with sign/zero extension.
        access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 3, '{32'h100, 32'h0, 4'h0, 1'b0}, '{1'b1, 1'b0, 32'hDEADBEEF, 4});
        access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 1, '{32'h100, 32'h0, 4'h0, 1'b0}, '{1'b1, 1'b0, 32'hFFFFFF80, 2});
        access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 1, '{32'h100, 32'h0, 4'h0, 1'b0}, '{1'b1, 1'b0, 32'h00000080, 2});
        access(1, 0, 3'b101, 32'h102, 32'h0, 32'h80FF0000, 1, '{32'h100, 32'h0, 4'h0, 1'b0}, '{1'b1, 1'b0, 32'h000080FF, 2});
        access(1, 0, 3'b001, 32'h100, 32'h0, 32'h12348001, 2, '{32'h100, 32'h0, 4'h0, 1'b0}, '{1'b1, 1'b0, 32'hFFFF8001, 3});

        // Stores: ReadData must keep the last load value.
        access(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 2, '{32'h200, 32'hABCDABCD, 4'b1100, 1'b1}, '{1'b1, 1'b0, 32'hFFFF8001, 3});
        access(0, 1, 3'b000, 32'h201, 32'h00000055, 32'h0, 1, '{32'h200, 32'h55555555, 4'b0010, 1'b1}, '{1'b1, 1'b0, 32'hFFFF8001, 2});
        access(1, 1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0, 1, '{32'h300, 32'hCAFEF00D, 4'b1111, 1'b1}, '{1'b1, 1'b0, 32'hFFFF8001, 2});

        // Rejected requests.
        bad_req(1, 0, 3'b010, 32'h101, 32'hFFFF8001);
        bad_req(0, 1, 3'b001, 32'h203, 32'hFFFF8001);
        bad_req(0, 1, 3'b100, 32'h200, 32'hFFFF8001);
        bad_req(1, 0, 3'b011, 32'h200, 32'hFFFF8001);
        bad_req(1, 0, 3'b001, 32'h101, 32'hFFFF8001);

        // Timeout, then ready on the last allowed cycle.
        access(1, 0, 3'b010, 32'h104, 32'h0, 32'h77777777, 0, '{32'h104, 32'h0, 4'h0, 1'b0}, '{1'b1, 1'b1, 32'h0, 5});
        access(1, 0, 3'b010, 32'h108, 32'h0, 32'hA5A5A5A5, MAXW, '{32'h108, 32'h0, 4'h0, 1'b0}, '{1'b1, 1'b0, 32'hA5A5A5A5, 5});

        // Reset during ACCESS of a store.
        bus_q.push_back('{32'h400, 32'h11112222, 4'b1111, 1'b1});
        MemWrite = 1'b1; Funct3 = 3'b010; ALUResult = 32'h400; WriteData = 32'h11112222;
        @(posedge CLK); #1;
        MemWrite = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        #1;
        checks++;
        if (ReadData !== 32'h0 || Stall !== 1'b0 || Done !== 1'b0 || Fault !== 1'b0 ||
            BusValid !== 1'b0 || BusAddr !== 32'h0 || BusWData !== 32'h0 ||
            BusWStrb !== 4'h0 || BusWrite !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_access: rdata=%h stall=%b done=%b fault=%b valid=%b addr=%h wdata=%h strb=%b wr=%b, required all 0",
                     ReadData, Stall, Done, Fault, BusValid, BusAddr, BusWData, BusWStrb, BusWrite);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        access(1, 0, 3'b010, 32'h10, 32'h0, 32'h12345678, 1, '{32'h10, 32'h0, 4'h0, 1'b0}, '{1'b1, 1'b0, 32'h12345678, 2});

        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (bus_q.size() != 0 || rsp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending bus=%0d rsp=%0d, required 0 and 0", bus_q.size(), rsp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage directly downstream of the ALU. It takes ALUResult as the effective address, plus rs2 store data and funct3. It performs byte, halfword or word loads and stores over a valid/ready data bus, and returns formatted (sign- or zero-extended) ReadData to write-back. Stall holds the PC and register file while a bus transaction is in flight.

Parameters:
WIDTH, 32, data width; 32 is the only supported value.
ADDR_WIDTH, 32, width of the effective address and BusAddr.
MAX_WAIT, 255, maximum ACCESS cycles before a bus timeout; must be at least 1.

Ports:
CLK  input  1  clock, rising edge.
RST  input  1  asynchronous, active-high reset.
MemRead  input  1  load request from decoder.
MemWrite  input  1  store request from decoder.
Funct3  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
ALUResult  input  ADDR_WIDTH  effective address from the ALU.
WriteData  input  WIDTH  rs2 store data.
ReadData  output  WIDTH  formatted load result, registered.
Stall  output  1  freeze PC and register file.
Done  output  1  one-cycle completion pulse.
Fault  output  1  misaligned, illegal funct3, or bus timeout.
BusAddr  output  ADDR_WIDTH  word-aligned address (low two bits 0).
BusWData  output  WIDTH  lane-replicated store data.
BusWStrb  output  4  byte-lane write strobes.
BusWrite  output  1  1 = write, 0 = read.
BusValid  output  1  request valid.
BusReady  input  1  slave accepts; read data valid in the same cycle.
BusRData  input  WIDTH  read data.

Behaviour:
- Reset (async, RST=1): state=IDLE. ReadData, BusAddr, BusWData, BusWStrb, BusWrite, BusValid, Done, Fault, wait counter all 0. Stall forced 0.
- req = MemRead|MemWrite. If both are set, the access is a store (MemWrite wins).
- bad (combinational) when any of the following holds:
  - Funct3 in {011,110,111};
  - a store with Funct3 in {100,101};
  - H/HU with ALUResult[0]=1;
  - W with ALUResult[1:0]!=0.
- State IDLE:
  - req & bad: Fault=1 combinationally in the same cycle, Stall=0, no bus activity, stay IDLE.
  - req & !bad: Stall=1 combinationally. Register the following on the clock edge, then go to ACCESS:
    - BusAddr={ALUResult[ADDR_WIDTH-1:2],2'b00}, BusWrite=MemWrite, BusValid=1;
    - byte offset ALUResult[1:0], Funct3;
    - BusWData: B = 4 copies of WriteData[7:0]; H = 2 copies of WriteData[15:0]; W = WriteData;
    - BusWStrb: B = 0001<<off; H = 0011<<{off[1],0}; W = 1111; reads = 0000.
- State ACCESS:
  - Stall=1. BusValid, BusAddr, BusWData, BusWStrb and BusWrite are held stable until the handshake completes.
  - BusReady=1 sampled:
    - BusValid->0 next cycle, go DONE.
    - On reads, ReadData is loaded with the selected lane. B/BU use byte lane off; H/HU use halfword lane off[1]. B/H sign-extend, BU/HU zero-extend, W passes through.
    - On writes, ReadData is unchanged.
  - Wait counter increments each ACCESS cycle without BusReady. When it reaches MAX_WAIT: BusValid->0, ReadData->0, timeout flag set, go DONE.
- State DONE (exactly one cycle):
  - Done=1, Stall=0, Fault=timeout flag.
  - New requests are ignored (prevents re-issue of the same instruction).
  - Clear the counter and timeout flag, go IDLE.
- Latency: request to Done is 2 + (ACCESS cycles) clock edges. Minimum is 3 cycles, with Stall high for 2.
- Reset mid-ACCESS: BusValid drops immediately (async) and the transaction is abandoned. The bus slave must tolerate the abandoned request.
- ReadData holds its last value between loads.

Test Plan:
1. LW ALUResult=0x100, BusRData=0xDEADBEEF, BusReady high on 3rd ACCESS cycle -> BusAddr=0x100, BusWrite=0, Stall high 4 cycles, then Done pulse, ReadData=0xDEADBEEF.
2. LB ALUResult=0x103, BusRData=0x80FF0000, ready immediately -> ReadData=0xFFFFFF80; repeat with LBU -> ReadData=0x00000080; LHU ALUResult=0x102 -> 0x000080FF.
3. SH ALUResult=0x202, WriteData=0x1234ABCD -> BusAddr=0x200, BusWData=0xABCDABCD, BusWStrb=1100, BusWrite=1, ReadData unchanged after Done.
4. LW ALUResult=0x101, and separately SH ALUResult=0x203 -> Fault=1 same cycle, Stall=0, BusValid never asserted, state stays IDLE.
5. LW with BusReady held low, MAX_WAIT=4 -> BusValid high 4 cycles then drops; DONE cycle shows Done=1, Fault=1, ReadData=0.
6. RST pulsed during ACCESS of an SW -> all outputs 0 immediately; a subsequent LW ALUResult=0x10 with BusRData=0x12345678 completes normally with ReadData=0x12345678.
